// File: rtl/acc_pkg.sv
// ============================================================================
// acc_pkg : FSM state encoding and saturation bounds for acc_requant
// Rev 1.0 | ACC_RELU_EN defined clamps the lower bound to zero
// ============================================================================
`default_nettype none

package acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_QUANT = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam int OW_DEF = 8;

  function automatic int qmax(input int ow);
    return (1 << (ow - 1)) - 1;
  endfunction

  function automatic int qmin(input int ow);
`ifdef ACC_RELU_EN
    return 0;
`else
    return -(1 << (ow - 1));
`endif
  endfunction

  localparam int QMAX = qmax(OW_DEF);
  localparam int QMIN = qmin(OW_DEF);

endpackage

`default_nettype wire

// File: rtl/requant_lane.sv
// ============================================================================
// requant_lane : round-half-up arithmetic right shift then saturate, one lane
// Rev 1.0 | bounds follow ACC_RELU_EN through acc_pkg
// ============================================================================
`default_nettype none

module requant_lane
  import acc_pkg::*;
#(
  parameter int DW = 32,
  parameter int SW = 5,
  parameter int OW = 8
) (
  input  logic [DW-1:0] x_i,
  input  logic [SW-1:0] shift_i,
  output logic [OW-1:0] q_o
);

  localparam logic signed [DW:0] HI = (DW+1)'(qmax(OW));
  localparam logic signed [DW:0] LO = (DW+1)'(qmin(OW));

  logic signed [DW:0] x_ext;
  logic signed [DW:0] rnd;
  logic signed [DW:0] sum;
  logic signed [DW:0] shr;

  // One extra bit keeps x + 2^(sh-1) from overflowing before the shift.
  always_comb begin
    x_ext = {x_i[DW-1], x_i};
    rnd   = '0;
    if (shift_i != '0) rnd = (DW+1)'(1) << (shift_i - SW'(1));
    sum = x_ext + rnd;
    shr = sum >>> shift_i;
    if (shr > HI)      q_o = HI[OW-1:0];
    else if (shr < LO) q_o = LO[OW-1:0];
    else               q_o = shr[OW-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/acc_requant.sv
// ============================================================================
// acc_requant : multi-tile row accumulate, bias, requantize, valid/ready out
// Rev 1.0 | ACC_RELU_EN selects ReLU saturation (see acc_pkg)
// ============================================================================
`default_nettype none

module acc_requant
  import acc_pkg::*;
#(
  parameter int DW = 32,
  parameter int DP = 56,
  parameter int OW = 8,
  parameter int TW = 8,
  parameter int SW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW*DP-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [DW-1:0]    bias_i,
  input  logic [TW-1:0]    cfg_tiles,
  input  logic [SW-1:0]    cfg_shift,
  output logic [OW*DP-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             err_o
);

  state_t           state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    tiles_q, tiles_d, tiles_eff;
  logic [SW-1:0]    shift_q, shift_d;
  logic [DW-1:0]    buf_q [DP];
  logic [DW-1:0]    buf_d [DP];
  logic [OW*DP-1:0] data_q, data_d, q_lanes;
  logic             err_q, err_d;

  assign ready_o   = (state_q == ST_IDLE) || (state_q == ST_ACC);
  assign valid_o   = (state_q == ST_OUT);
  assign busy_o    = (state_q != ST_IDLE);
  assign err_o     = err_q;
  assign data_o    = data_q;
  assign tiles_eff = (cfg_tiles == '0) ? TW'(1) : cfg_tiles;

  for (genvar i = 0; i < DP; i++) begin : g_lane
    requant_lane #(.DW(DW), .SW(SW), .OW(OW)) u_lane (
      .x_i     (buf_q[i]),
      .shift_i (shift_q),
      .q_o     (q_lanes[OW*i +: OW])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tiles_d = tiles_q;
    shift_d = shift_q;
    buf_d   = buf_q;
    data_d  = data_q;
    err_d   = err_q | (valid_i & ~ready_o);
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          for (int i = 0; i < DP; i++) buf_d[i] = data_i[DW*i +: DW] + bias_i;
          tiles_d = tiles_eff;
          shift_d = cfg_shift;
          cnt_d   = TW'(1);
          state_d = (tiles_eff == TW'(1)) ? ST_QUANT : ST_ACC;
        end
      end
      ST_ACC: begin
        if (valid_i) begin
          for (int i = 0; i < DP; i++) buf_d[i] = buf_q[i] + data_i[DW*i +: DW];
          cnt_d = cnt_q + TW'(1);
          if (cnt_d == tiles_q) state_d = ST_QUANT;
        end
      end
      ST_QUANT: begin
        data_d  = q_lanes;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tiles_q <= TW'(1);
      shift_q <= '0;
      for (int i = 0; i < DP; i++) buf_q[i] <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tiles_q <= tiles_d;
      shift_q <= shift_d;
      for (int i = 0; i < DP; i++) buf_q[i] <= buf_d[i];
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_acc_requant.sv
// ============================================================================
// tb_acc_requant : directed self-checking bench for acc_requant
// Rev 1.0 | expectations adapt to ACC_RELU_EN
// ============================================================================
`default_nettype none

module tb_acc_requant;

  localparam int DW = 32;
  localparam int DP = 56;
  localparam int OW = 8;
  localparam int TW = 8;
  localparam int SW = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DW*DP-1:0] data_i;
  logic             valid_i;
  logic             ready_o;
  logic [DW-1:0]    bias_i;
  logic [TW-1:0]    cfg_tiles;
  logic [SW-1:0]    cfg_shift;
  logic [OW*DP-1:0] data_o;
  logic             valid_o;
  logic             ready_i;
  logic             busy_o;
  logic             err_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  acc_requant #(.DW(DW), .DP(DP), .OW(OW), .TW(TW), .SW(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .bias_i    (bias_i),
    .cfg_tiles (cfg_tiles),
    .cfg_shift (cfg_shift),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .busy_o    (busy_o),
    .err_o     (err_o)
  );

  function automatic int relu(input int v);
`ifdef ACC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input int v);
    data_i[DW*i +: DW] = v[DW-1:0];
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
    bias_i = '0; cfg_tiles = '0; cfg_shift = '0;
    tick(); tick();
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    checks++; if (busy_o !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (err_o !== 1'b0)   begin errors++; $display("FAIL reset_err: got %b want 0", err_o); end
    checks++; if (data_o !== '0)    begin errors++; $display("FAIL reset_data: got %h want 0", data_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int exp_l [DP];
    data_i = '0; set_lane(0, 5); set_lane(1, -3);
    cfg_tiles = 8'd1; cfg_shift = '0; bias_i = '0; valid_i = 1'b1;
    tick(); valid_i = 1'b0;
    checks++; if (ready_o !== 1'b0 || valid_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL basic_quant_flags: got r=%b v=%b b=%b want r=0 v=0 b=1", ready_o, valid_o, busy_o);
    end
    tick();
    for (int i = 0; i < DP; i++) exp_l[i] = 0;
    exp_l[0] = 5; exp_l[1] = relu(-3);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", valid_o); end
    for (int i = 0; i < DP; i++) begin
      checks++;
      if (data_o[OW*i +: OW] !== OW'(exp_l[i])) begin
        errors++; $display("FAIL basic_lane%0d: got %0d want %0d", i, $signed(data_o[OW*i +: OW]), exp_l[i]);
      end
    end
    ready_i = 1'b1; tick(); ready_i = 1'b0;
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL basic_handshake: got v=%b r=%b b=%b want v=0 r=1 b=0", valid_o, ready_o, busy_o);
    end
  endtask

  task automatic test_multi(input int ntiles, input int val, input int bias, input int sh, input int expv);
    for (int t = 0; t < ntiles; t++) begin
      for (int i = 0; i < DP; i++) set_lane(i, val);
      // Later tiles carry junk config, which must be ignored.
      cfg_tiles = (t == 0) ? TW'(ntiles) : '0;
      cfg_shift = (t == 0) ? SW'(sh) : SW'(sh ^ 1);
      bias_i    = (t == 0) ? DW'(bias) : DW'(999);
      valid_i = 1'b1; tick(); valid_i = 1'b0;
      if (t == 0) begin
        tick();
        checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b1) begin
          errors++; $display("FAIL multi_gap: got r=%b v=%b b=%b want r=1 v=0 b=1", ready_o, valid_o, busy_o);
        end
      end else if (t < ntiles - 1) begin
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL multi_acc_ready: got %b want 1", ready_o); end
      end
    end
    checks++; if (ready_o !== 1'b0 || valid_o !== 1'b0) begin
      errors++; $display("FAIL multi_quant: got r=%b v=%b want r=0 v=0", ready_o, valid_o);
    end
    tick();
    checks++; if (ready_o !== 1'b0 || valid_o !== 1'b1) begin
      errors++; $display("FAIL multi_out: got r=%b v=%b want r=0 v=1", ready_o, valid_o);
    end
    for (int i = 0; i < DP; i++) begin
      checks++;
      if (data_o[OW*i +: OW] !== OW'(expv)) begin
        errors++; $display("FAIL multi_lane%0d: got %0d want %0d", i, $signed(data_o[OW*i +: OW]), expv);
      end
    end
    ready_i = 1'b1; tick(); ready_i = 1'b0;
  endtask

  task automatic test_round_sat();
    int in_l [2][5];
    int ex_l [2][5];
    in_l = '{'{6, -6, 5, -5, -2}, '{1000, -1000, 127, -128, 0}};
    ex_l = '{'{2, relu(-1), 1, relu(-1), 0}, '{127, relu(-128), 127, relu(-128), 0}};
    for (int r = 0; r < 2; r++) begin
      data_i = '0;
      for (int i = 0; i < 5; i++) set_lane(i, in_l[r][i]);
      cfg_tiles = 8'd1; cfg_shift = (r == 0) ? SW'(2) : SW'(0); bias_i = '0;
      valid_i = 1'b1; tick(); valid_i = 1'b0; tick();
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL rs_valid row%0d: got %b want 1", r, valid_o); end
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (data_o[OW*i +: OW] !== OW'(ex_l[r][i])) begin
          errors++; $display("FAIL rs_row%0d_lane%0d: got %0d want %0d", r, i, $signed(data_o[OW*i +: OW]), ex_l[r][i]);
        end
      end
      ready_i = 1'b1; tick(); ready_i = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [OW*DP-1:0] expv;
    int neg;
    neg = relu(-7);
    expv = '0; expv[OW*0 +: OW] = 8'd42; expv[OW*5 +: OW] = neg[OW-1:0];
    data_i = '0; set_lane(0, 42); set_lane(5, -7);
    cfg_tiles = 8'd1; cfg_shift = '0; bias_i = '0;
    valid_i = 1'b1; tick(); valid_i = 1'b0; tick();
    for (int c = 0; c < 5; c++) begin
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d: got %b want 1", c, valid_o); end
      checks++; if (data_o !== expv) begin errors++; $display("FAIL bp_data c%0d: got %h want %h", c, data_o, expv); end
      if (c == 1) begin
        for (int i = 0; i < DP; i++) set_lane(i, 99);
        valid_i = 1'b1;
      end
      tick(); valid_i = 1'b0;
    end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL bp_err_set: got %b want 1", err_o); end
    ready_i = 1'b1; tick(); ready_i = 1'b0;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", valid_o); end
    tick();
    checks++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL bp_sticky: got err=%b busy=%b want err=1 busy=0", err_o, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < DP; i++) set_lane(i, 50);
    cfg_tiles = 8'd3; cfg_shift = '0; bias_i = '0;
    valid_i = 1'b1; tick(); tick(); valid_i = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++; if (busy_o !== 1'b0 || ready_o !== 1'b1 || valid_o !== 1'b0 || err_o !== 1'b0) begin
      errors++; $display("FAIL midrst_flags: got b=%b r=%b v=%b e=%b want b=0 r=1 v=0 e=0", busy_o, ready_o, valid_o, err_o);
    end
    checks++; if (data_o !== '0) begin errors++; $display("FAIL midrst_data: got %h want 0", data_o); end
    data_i = '0; set_lane(0, 7);
    cfg_tiles = 8'd1; cfg_shift = '0;
    valid_i = 1'b1; tick(); valid_i = 1'b0; tick();
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL midrst_valid: got %b want 1", valid_o); end
    checks++; if (data_o[OW-1:0] !== 8'd7) begin errors++; $display("FAIL midrst_lane0: got %0d want 7", $signed(data_o[OW-1:0])); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b want 0", err_o); end
    ready_i = 1'b1; tick(); ready_i = 1'b0;
  endtask

  task automatic test_tiles_zero();
    data_i = '0; set_lane(0, 9);
    cfg_tiles = '0; cfg_shift = '0; bias_i = '0;
    valid_i = 1'b1; tick(); valid_i = 1'b0;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL tz_quant: got ready=%b want 0", ready_o); end
    tick();
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL tz_valid: got %b want 1", valid_o); end
    checks++; if (data_o[OW-1:0] !== 8'd9) begin errors++; $display("FAIL tz_lane0: got %0d want 9", $signed(data_o[OW-1:0])); end
    ready_i = 1'b1; tick(); ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi(3, 100, 10, 2, 78);
    test_multi(2, 20, -4, 1, 18);
    test_round_sat();
    test_backpressure();
    test_reset_mid();
    test_tiles_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/acc_requant.md
# acc_requant

Post-accumulation stage directly downstream of the 3x3/1x1/identity partial-sum accumulator. Each incoming row is DP lanes of DW-bit signed partial sums for one input-channel tile. The block sums `cfg_tiles` such rows in a row buffer, adds a per-output-channel bias, applies round-half-up arithmetic right shift, optional ReLU and saturation, and presents a DP-lane OW-bit row to the feature-map writer over a valid/ready handshake.

## Interface

Parameters:
- `DW`, 32: partial-sum lane width, signed two's complement.
- `DP`, 56: lanes per row.
- `OW`, 8: output lane width, signed.
- `TW`, 8: width of tile counter / `cfg_tiles`.
- `SW`, 5: width of `cfg_shift`.

Ports:
- `clk` in 1: clock. One clock domain.
- `rst_n` in 1: reset. Synchronous, active-low.
- `data_i` in DW*DP: partial-sum row; lane i at `[DW*i+:DW]`.
- `valid_i` in 1: `data_i` valid this cycle.
- `ready_o` out 1: block can accept a tile this cycle.
- `bias_i` in DW: bias for the current output channel. Sampled with the first tile of a row.
- `cfg_tiles` in TW: tiles per output row. 0 is treated as 1. Sampled with the first tile.
- `cfg_shift` in SW: requant right-shift amount. Sampled with the first tile.
- `data_o` out OW*DP: quantized row; lane i at `[OW*i+:OW]`.
- `valid_o` out 1: `data_o` valid.
- `ready_i` in 1: downstream accepts `data_o`.
- `busy_o` out 1: high whenever state is not IDLE.
- `err_o` out 1: sticky. Set when `valid_i` is high while `ready_o` is low. Cleared only by reset.

## Operation

- FSM states: IDLE, ACC, QUANT, OUT.
- `ready_o` = 1 in IDLE and ACC; 0 in QUANT and OUT.
- IDLE, `valid_i`:
  - `buf[i] <= data_i[i] + bias_i`.
  - Latch `cfg_tiles` (0→1) and `cfg_shift`.
  - `cnt <= 1`.
  - Go to QUANT if the latched tile count is 1, else ACC.
- ACC, `valid_i`:
  - `buf[i] <= buf[i] + data_i[i]`, `cnt <= cnt+1`.
  - Go to QUANT when `cnt+1 == tiles`.
  - With `valid_i` low, hold state and buffer.
- QUANT (always exactly one cycle): per lane, `data_o` is registered as requant(`buf[i]`); then go to OUT.
- OUT:
  - `valid_o` = 1.
  - When `valid_o && ready_i` at an edge, go to IDLE. `valid_o` is 0 the next cycle.
  - `data_o` holds its value until the next QUANT.
- Arithmetic:
  - Accumulation and bias add are DW-bit and wrap modulo 2^DW.
  - Requant is computed in DW+1 bits: `sh==0` gives `x`; otherwise `(x + 2^(sh-1)) >>> sh` (arithmetic shift).
  - Saturate to [-2^(OW-1), 2^(OW-1)-1]. With ReLU enabled, the lower bound is 0.
- `valid_i` in QUANT/OUT: the tile is dropped and `err_o` is set. Buffer and state are unaffected.
- Reset (any state, including mid-row):
  - Next edge: state IDLE, `cnt`=0, `buf`=0, `data_o`=0, `valid_o`=0, `err_o`=0, `busy_o`=0.
  - `ready_o` is 1 from the first cycle after reset.
  - The partial row is discarded.

## Timing

- Latency: last tile sampled at edge k → `valid_o` high after edge k+1.
- Single-tile row: `valid_o` high 2 cycles after `valid_i`.
- Minimum row period: `tiles` + 2 cycles, plus one cycle per cycle of `ready_i` backpressure.
- No combinational path from `valid_i`/`ready_i` to any output. `ready_o` and `valid_o` decode from the state register only.

## Configuration

- `ACC_RELU_EN` defined: lanes saturate to [0, 2^(OW-1)-1]; negative results output 0.
- `ACC_RELU_EN` undefined: lanes saturate to [-2^(OW-1), 2^(OW-1)-1]; signed output.

## Structure

- Package `acc_pkg` holds:
  - FSM state enum (IDLE/ACC/QUANT/OUT).
  - `QMAX`/`QMIN` constants derived from OW and `ACC_RELU_EN`.
- Sub-module `requant_lane`:
  - Combinational: DW-bit in, SW-bit shift, OW-bit out (round, shift, saturate).
  - Instantiated DP times in a generate loop; its output is registered in the top during QUANT.

## Test plan

- Basic: `cfg_tiles`=1, `shift`=0, `bias`=0, lane0=5, lane1=-3 → `valid_o` 2 cycles later; lane0=5; lane1=0 with `ACC_RELU_EN`, -3 without.
- Multi-tile: `cfg_tiles`=3, three rows of 100 on all lanes, `bias`=10, `shift`=2 → all lanes 78; `ready_o` 0 during QUANT/OUT.
- Round/saturate:
  - `shift`=2, lane=6 → 2; lane=-6 → -1 (0 with ReLU).
  - `shift`=0, lane=1000 → 127; lane=-1000 → -128 (0 with ReLU).
- Backpressure: `ready_i` low 5 cycles in OUT → `valid_o` and `data_o` stable. `valid_i` pulsed meanwhile → `err_o` 1 and stays 1; result unaffected.
- Reset mid-row: `cfg_tiles`=3, 2 tiles sent, `rst_n` low 1 cycle, then single-tile row lane=7, `shift`=0 → output 7. `err_o`=0.
- `cfg_tiles`=0 with one tile of 9 → behaves as 1 tile, output 9.
